// File: rtl/sync_fifo_rtl.sv
// Single-clock first-word-fall-through FIFO.
// Storage is a DEPTH x D_WIDTH register array. The read and write pointers carry
// one extra wrap bit, which lets full and empty be told apart when the low bits match.
// r_data always shows the oldest stored word. rd only advances the read pointer.
module sync_fifo_rtl #(
    parameter int DEPTH   = 8,
    parameter int D_WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic               rd,
    input  logic [D_WIDTH-1:0] w_data,
    output logic [D_WIDTH-1:0] r_data,
    output logic               full,
    output logic               empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]        wr_ptr_reg;
    logic [AW:0]        rd_ptr_reg;
    logic [D_WIDTH-1:0] mem_reg [DEPTH];

    logic               wr_en;
    logic               rd_en;
    logic [DEPTH-1:0]   wr_sel;

    // The flags come only from the pointers. No strobe reaches an output combinationally.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                   (wr_ptr_reg[AW] != rd_ptr_reg[AW]);

    // A write into a full FIFO is dropped. A read from an empty FIFO is ignored.
    // When the FIFO is full, a simultaneous read still succeeds because full is taken from the pre-edge pointers.
    assign wr_en = wr && !full;
    assign rd_en = rd && !empty;

    // Head word is presented straight from storage (first-word-fall-through)
    assign r_data = mem_reg[rd_ptr_reg[AW-1:0]];

    // One-hot decode of the storage entry targeted by an accepted write
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_en && (wr_ptr_reg[AW-1:0] == AW'(gi));
        end
    endgenerate

    // Pointer update: each pointer advances on its accepted request. The low bits roll over and the wrap bit toggles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + {{AW{1'b0}}, 1'b1};
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage: cleared on reset so r_data is a known zero afterwards. Each accepted write lands in its selected entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel[i]) begin
                    mem_reg[i] <= w_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_rtl.sv
// Directed bench for sync_fifo_rtl (DEPTH=8, D_WIDTH=8).
// Inputs change on the falling edge. Outputs are sampled 1 time unit after the rising edge.
module tb_sync_fifo_rtl;

    logic       clk;
    logic       reset;
    logic       wr;
    logic       rd;
    logic [7:0] w_data;
    logic [7:0] r_data;
    logic       full;
    logic       empty;

    int checks;
    int fails;

    sync_fifo_rtl #(.DEPTH(8), .D_WIDTH(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .wr     (wr),
        .rd     (rd),
        .w_data (w_data),
        .r_data (r_data),
        .full   (full),
        .empty  (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply the strobes for one rising edge, then return the strobes to idle.
    task automatic op(input logic w, input logic r, input logic [7:0] d);
        @(negedge clk);
        wr     = w;
        rd     = r;
        w_data = d;
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
        $display("t=%0t wr=%0b rd=%0b w_data=%02h -> r_data=%02h full=%0b empty=%0b",
                 $time, w, r, d, r_data, full, empty);
    endtask

    // Check the head word, then pop it.
    task automatic pop_expect(input string tag, input logic [7:0] exp);
        check(tag, 32'(r_data), 32'(exp));
        op(1'b0, 1'b1, 8'h00);
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        wr     = 1'b0;
        rd     = 1'b0;
        w_data = 8'h00;

        // 1: reset
        reset = 1'b1;
        #5;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_rdata", 32'(r_data), 32'h00);
        op(1'b0, 1'b0, 8'h5A);
        check("idle_empty", 32'(empty), 32'd1);
        check("idle_rdata", 32'(r_data), 32'h00);

        // 2: six writes with idle cycles between them
        op(1'b1, 1'b0, 8'h05);
        check("w1_empty", 32'(empty), 32'd0);
        check("w1_rdata", 32'(r_data), 32'h05);
        for (int i = 0; i < 4; i++) begin
            op(1'b0, 1'b0, 8'h00);
            op(1'b1, 1'b0, 8'h06);
        end
        op(1'b0, 1'b0, 8'h00);
        op(1'b1, 1'b0, 8'h02);
        check("w6_full", 32'(full), 32'd0);
        check("w6_rdata", 32'(r_data), 32'h05);

        // 3: one pop; the head advances, and a later idle rd does not change it
        op(1'b0, 1'b1, 8'h00);
        check("pop1_rdata", 32'(r_data), 32'h06);
        op(1'b0, 1'b0, 8'h00);
        check("pop1_hold", 32'(r_data), 32'h06);

        // 4: fill to full; the fourth write is dropped
        op(1'b1, 1'b0, 8'h03);
        check("w7_full", 32'(full), 32'd0);
        op(1'b1, 1'b0, 8'h03);
        check("w8_full", 32'(full), 32'd0);
        op(1'b1, 1'b0, 8'h03);
        check("w9_full", 32'(full), 32'd1);
        op(1'b1, 1'b0, 8'h03);
        check("drop_full", 32'(full), 32'd1);
        check("drop_rdata", 32'(r_data), 32'h06);
        pop_expect("d0", 8'h06);
        check("d0_full", 32'(full), 32'd0);
        pop_expect("d1", 8'h06);
        pop_expect("d2", 8'h06);
        pop_expect("d3", 8'h06);
        pop_expect("d4", 8'h02);
        pop_expect("d5", 8'h03);
        pop_expect("d6", 8'h03);
        check("d6_empty", 32'(empty), 32'd0);
        pop_expect("d7", 8'h03);
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_full", 32'(full), 32'd0);

        // 5: two fill/drain rounds carry both pointers past 2*DEPTH transfers
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++) begin
                op(1'b1, 1'b0, 8'(8'h40 + r * 16 + i));
            end
            check("wrap_full", 32'(full), 32'd1);
            check("wrap_notempty", 32'(empty), 32'd0);
            for (int i = 0; i < 8; i++) begin
                pop_expect("wrap_data", 8'(8'h40 + r * 16 + i));
            end
            check("wrap_empty", 32'(empty), 32'd1);
            check("wrap_notfull", 32'(full), 32'd0);
        end

        // 6a: rd while empty does nothing; the next write becomes the head
        op(1'b0, 1'b1, 8'h00);
        check("rdempty_empty", 32'(empty), 32'd1);
        op(1'b1, 1'b0, 8'h77);
        check("rdempty_head", 32'(r_data), 32'h77);
        pop_expect("rdempty_pop", 8'h77);
        check("rdempty_empty2", 32'(empty), 32'd1);

        // 6b: wr+rd while full pops only; the write data is not stored
        for (int i = 0; i < 8; i++) begin
            op(1'b1, 1'b0, 8'(8'hA0 + i));
        end
        check("full_before", 32'(full), 32'd1);
        op(1'b1, 1'b1, 8'hEE);
        check("wrrd_full_clear", 32'(full), 32'd0);
        check("wrrd_full_head", 32'(r_data), 32'hA1);

        // 6c: wr+rd at mid occupancy (7) keeps occupancy and order
        op(1'b1, 1'b1, 8'hB0);
        check("mid_head", 32'(r_data), 32'hA2);
        check("mid_full", 32'(full), 32'd0);
        op(1'b1, 1'b0, 8'hB1);
        check("mid_refill_full", 32'(full), 32'd1);
        for (int i = 2; i < 8; i++) begin
            pop_expect("mid_order", 8'(8'hA0 + i));
        end
        pop_expect("mid_b0", 8'hB0);
        pop_expect("mid_b1", 8'hB1);
        check("mid_empty", 32'(empty), 32'd1);

        // 6d: asynchronous reset in mid-stream
        op(1'b1, 1'b0, 8'hC0);
        op(1'b1, 1'b0, 8'hC1);
        check("pre_rst_empty", 32'(empty), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_empty", 32'(empty), 32'd1);
        check("async_rst_full", 32'(full), 32'd0);
        check("async_rst_rdata", 32'(r_data), 32'h00);
        @(negedge clk);
        reset = 1'b0;
        op(1'b1, 1'b0, 8'hD0);
        check("post_rst_head", 32'(r_data), 32'hD0);
        check("post_rst_empty", 32'(empty), 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
